divider_seq: RTL

- Sequential restoring divider: the inverse companion of the team's 4-bit start/valid multiplier.
- Divides an 8-bit dividend (a multiplier product) by a 4-bit divisor, one quotient bit per clock.
- Returns quotient and remainder with a one-cycle valid pulse.
- Drives the same two-digit 7-segment display pair with the quotient in hex.

---
 rtl/divider_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
//  Module   : divider_seq
//  Purpose  : 8-bit / 4-bit sequential restoring divider, one quotient bit
//             per clock, with the quotient shown on a two-digit 7-seg pair.
//  Revision : 1.0  initial release
// ============================================================================
module divider_seq #(
    parameter bit FND_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       valid,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero,
    output logic [6:0] fnd_01,
    output logic [6:0] fnd_02
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_q;
    logic [7:0] r_p;
    logic [3:0] r_dvs;
    logic [2:0] r_cnt;
    logic       r_zero;
    logic [7:0] r_quot;
    logic [3:0] r_rem;
    logic       r_dbz;
    logic       r_busy;
    logic       r_valid;

    logic [8:0] w_p_shift;
    logic [7:0] w_p_sub;
    logic       w_ge;

    // Remainder after a successful subtract is below the divisor, so the
    // low 8 bits of the difference are exact.
    assign w_p_shift = {r_p, r_q[7]};
    assign w_ge      = (w_p_shift >= {5'b0, r_dvs});
    assign w_p_sub   = w_p_shift[7:0] - {4'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_q     <= 8'd0;
            r_p     <= 8'd0;
            r_dvs   <= 4'd0;
            r_cnt   <= 3'd0;
            r_zero  <= 1'b0;
            r_quot  <= 8'd0;
            r_rem   <= 4'd0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_q     <= dividend;
                        r_dvs   <= divisor;
                        r_p     <= 8'd0;
                        r_cnt   <= 3'd0;
                        r_zero  <= (divisor == 4'd0);
                        r_busy  <= 1'b1;
                        r_state <= (divisor == 4'd0) ? DONE : CALC;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                CALC: begin
                    r_p   <= w_ge ? w_p_sub : w_p_shift[7:0];
                    r_q   <= {r_q[6:0], w_ge};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_valid <= 1'b1;
                    if (r_zero) begin
                        r_quot <= 8'hFF;
                        r_rem  <= 4'h0;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= r_q;
                        r_rem  <= r_p[3:0];
                        r_dbz  <= 1'b0;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    localparam logic [6:0] c_seg_inv = {7{FND_ACTIVE_LOW}};

    assign fnd_01      = hex_to_seg(r_quot[3:0]) ^ c_seg_inv;
    assign fnd_02      = hex_to_seg(r_quot[7:4]) ^ c_seg_inv;
    assign busy        = r_busy;
    assign valid       = r_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
